// File: rtl/dist_ram_sync_q_if.sv
// Bus bundle for dist_ram_sync_q: address, write data/enable, output-register enable, read data.
// Optional spo (unregistered read) appears when DIST_RAM_SPO_EN is defined.
interface dist_ram_sync_q_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] d;
  logic                  we;
  logic                  qspo_ce;
  logic [DATA_WIDTH-1:0] qspo;
`ifdef DIST_RAM_SPO_EN
  logic [DATA_WIDTH-1:0] spo;

  modport master (output a, d, we, qspo_ce, input qspo, spo);
  modport slave  (input a, d, we, qspo_ce, output qspo, spo);
`else
  modport master (output a, d, we, qspo_ce, input qspo);
  modport slave  (input a, d, we, qspo_ce, output qspo);
`endif
endinterface

// File: rtl/dist_ram_sync_q.sv
// 64x32 single-port distributed RAM: synchronous write, combinational read into a
// registered output (qspo) with clock enable and sync reset. DIST_RAM_SPO_EN exposes spo.
module dist_ram_sync_q #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               qspo_srst,
  dist_ram_sync_q_if.slave   bus
);

  // Power-up contents come from declaration initialisers; qspo_srst never touches the array.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] qspo_q = '0;
  logic [DATA_WIDTH-1:0] qspo_d;
  logic [DATA_WIDTH-1:0] spo_w;

  always_comb begin
    spo_w = mem_q[bus.a];
  end

  always_comb begin
    qspo_d = qspo_q;
    if (bus.qspo_ce) qspo_d = spo_w;
  end

  // spo_w is sampled before the write lands, so same-address read-during-write returns the old word.
  always_ff @(posedge clk) begin
    if (qspo_srst) qspo_q <= '0;
    else           qspo_q <= qspo_d;
  end

  always_ff @(posedge clk) begin
    if (bus.we) mem_q[bus.a] <= bus.d;
  end

  assign bus.qspo = qspo_q;
`ifdef DIST_RAM_SPO_EN
  assign bus.spo  = spo_w;
`endif

endmodule

// File: tb/tb_dist_ram_sync_q.sv
// Directed self-checking bench for dist_ram_sync_q (both builds of DIST_RAM_SPO_EN).
module tb_dist_ram_sync_q;

  logic clk = 1'b0;
  logic qspo_srst;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  dist_ram_sync_q_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

  dist_ram_sync_q #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clk       (clk),
    .qspo_srst (qspo_srst),
    .bus       (bus)
  );

  // Drive on the falling edge, clock one rising edge, sample 1 ns later.
  task automatic drive(input logic srst, input logic we, input logic ce,
                       input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    qspo_srst   = srst;
    bus.we      = we;
    bus.qspo_ce = ce;
    bus.a       = a;
    bus.d       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_vec++;
    if (bus.qspo !== 32'h0) begin
      n_err++;
      $display("FAIL powerup_qspo: got %h want %h", bus.qspo, 32'h0);
    end
    drive(1'b1, 1'b0, 1'b1, 6'd0, 32'h0);
    n_vec++;
    if (bus.qspo !== 32'h0) begin
      n_err++;
      $display("FAIL reset_qspo: got %h want %h", bus.qspo, 32'h0);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 1'b0, 6'(i), 32'(i));
      n_vec++;
      if (bus.qspo !== 32'h0) begin
        n_err++;
        $display("FAIL fill_hold[%0d]: got %h want %h", i, bus.qspo, 32'h0);
      end
    end
  endtask

  task automatic test_read;
    logic [5:0]  addrs [3] = '{6'd0, 6'd1, 6'd15};
    logic [31:0] exp   [3] = '{32'h0, 32'h1, 32'h0000000F};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, addrs[i], 32'hFFFF_FFFF);
      n_vec++;
      if (bus.qspo !== exp[i]) begin
        n_err++;
        $display("FAIL read_a%0d: got %h want %h", addrs[i], bus.qspo, exp[i]);
      end
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 1'b1, 1'b0, 6'd2, 32'h22);
    n_vec++;
    if (bus.qspo !== 32'h0000000F) begin
      n_err++;
      $display("FAIL hold_ce0: got %h want %h", bus.qspo, 32'h0000000F);
    end
`ifdef DIST_RAM_SPO_EN
    n_vec++;
    if (bus.spo !== 32'h22) begin
      n_err++;
      $display("FAIL spo_after_write: got %h want %h", bus.spo, 32'h22);
    end
`endif
    drive(1'b0, 1'b0, 1'b1, 6'd2, 32'h0);
    n_vec++;
    if (bus.qspo !== 32'h22) begin
      n_err++;
      $display("FAIL hold_readback: got %h want %h", bus.qspo, 32'h22);
    end
  endtask

  task automatic test_srst_priority;
    drive(1'b0, 1'b0, 1'b1, 6'd15, 32'h0);
    n_vec++;
    if (bus.qspo !== 32'h0F) begin
      n_err++;
      $display("FAIL srst_preload: got %h want %h", bus.qspo, 32'h0F);
    end
    // Reset with ce=1 and a concurrent write to address 40.
    drive(1'b1, 1'b1, 1'b1, 6'd40, 32'h0000_1234);
    n_vec++;
    if (bus.qspo !== 32'h0) begin
      n_err++;
      $display("FAIL srst_over_ce: got %h want %h", bus.qspo, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b1, 6'd15, 32'h0);
    n_vec++;
    if (bus.qspo !== 32'h0F) begin
      n_err++;
      $display("FAIL srst_array_intact: got %h want %h", bus.qspo, 32'h0F);
    end
    drive(1'b0, 1'b0, 1'b1, 6'd40, 32'h0);
    n_vec++;
    if (bus.qspo !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL srst_write_commits: got %h want %h", bus.qspo, 32'h0000_1234);
    end
  endtask

  task automatic test_rdw;
    drive(1'b0, 1'b1, 1'b1, 6'd5, 32'hAA);
    n_vec++;
    if (bus.qspo !== 32'h5) begin
      n_err++;
      $display("FAIL rdw_old: got %h want %h", bus.qspo, 32'h5);
    end
    drive(1'b0, 1'b0, 1'b1, 6'd5, 32'h0);
    n_vec++;
    if (bus.qspo !== 32'hAA) begin
      n_err++;
      $display("FAIL rdw_new: got %h want %h", bus.qspo, 32'hAA);
    end
  endtask

  task automatic test_boundary;
    drive(1'b0, 1'b1, 1'b0, 6'd63, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 1'b1, 6'd63, 32'h0);
    n_vec++;
    if (bus.qspo !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL bound_a63: got %h want %h", bus.qspo, 32'hDEAD_BEEF);
    end
    drive(1'b0, 1'b0, 1'b1, 6'd0, 32'h0);
    n_vec++;
    if (bus.qspo !== 32'h0) begin
      n_err++;
      $display("FAIL bound_a0: got %h want %h", bus.qspo, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b1, 6'd32, 32'h0);
    n_vec++;
    if (bus.qspo !== 32'h0) begin
      n_err++;
      $display("FAIL bound_a32_unwritten: got %h want %h", bus.qspo, 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 16; i < 32; i++) begin
      drive(1'b0, 1'b0, 1'b1, 6'(i), 32'h0);
      n_vec++;
      if (bus.qspo !== 32'(i)) begin
        n_err++;
        $display("FAIL b2b_a%0d: got %h want %h", i, bus.qspo, 32'(i));
      end
    end
  endtask

  initial begin
    qspo_srst   = 1'b0;
    bus.we      = 1'b0;
    bus.qspo_ce = 1'b0;
    bus.a       = '0;
    bus.d       = '0;
    #1;
    test_reset();
    test_fill();
    test_read();
    test_hold();
    test_srst_priority();
    test_rdw();
    test_boundary();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
